fpro_bus_arbiter: RTL and testbench

- Shares the single FPro bus (the MMIO and video slave port) between two masters: m0 is the MCS bridge, m1 is a secondary master such as a DMA or sprite loader.
- Sequences each transfer as a one-cycle bus strobe, registers the read data, then returns an ack pulse.
- Sits between the bridge/secondary master and mmio_sys / video_sys. Arbitration is round-robin or fixed-priority.

---
 rtl/fpro_arb_pkg.sv | 21 ++
 rtl/fpro_arb_pick.sv | 27 ++
 rtl/fpro_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_fpro_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpro_arb_pkg.sv
// Shared types and default widths for the FPro bus arbiter: FSM states and the
// latched request record.
package fpro_arb_pkg;

  localparam int ADDR_W_DEF = 21;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  typedef struct packed {
    logic                  wr;
    logic                  video;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wr_data;
  } req_t;

endpackage

// File: rtl/fpro_arb_pick.sv
// Two-way winner select: round-robin on the pointer, or m0-first when
// FIXED_PRIO is set. Purely combinational.
module fpro_arb_pick #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic req0_i,
  input  logic req1_i,
  input  logic ptr_i,
  output logic valid_o,
  output logic sel_o
);

  // NOTE: every output gets a default at the top of always_comb so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    valid_o = req0_i | req1_i;
    sel_o   = 1'b0;
    if (FIXED_PRIO) begin
      sel_o = ~req0_i;
    end else if (req0_i && req1_i) begin
      sel_o = ptr_i;
    end else begin
      sel_o = req1_i;
    end
  end

endmodule

// File: rtl/fpro_bus_arbiter.sv
// Shares the FPro MMIO/video slave port between two masters. Each transfer is
// IDLE (grant) -> ISSUE (one-cycle strobe, read data captured) -> ACK (pulse).
module fpro_bus_arbiter
  import fpro_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic              m0_video,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rd_data,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic              m1_video,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              fp_mmio_cs,
  output logic              fp_video_cs,
  output logic              fp_wr,
  output logic              fp_rd,
  output logic [ADDR_W-1:0] fp_addr,
  output logic [DATA_W-1:0] fp_wr_data,
  input  logic [DATA_W-1:0] fp_rd_data,
  output logic              busy,
  output logic              owner
);

  // The latched request record is sized by the package, so the bus widths are
  // tied to it.
  if (ADDR_W != ADDR_W_DEF || DATA_W != DATA_W_DEF) begin : g_width_guard
    $error("fpro_bus_arbiter: ADDR_W/DATA_W must match fpro_arb_pkg widths");
  end

  state_e            state_q;
  req_t              req_q;
  req_t              gnt_req_d;
  logic              owner_q;
  logic              ptr_q;
  logic              busy_q;
  logic              mmio_cs_q;
  logic              video_cs_q;
  logic              wr_q;
  logic              rd_q;
  logic              m0_ack_q;
  logic              m1_ack_q;
  logic [DATA_W-1:0] m0_rd_q;
  logic [DATA_W-1:0] m1_rd_q;
  logic [DATA_W-1:0] rd_capture_d;
  logic              gnt_valid;
  logic              gnt_sel;

  fpro_arb_pick #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .req0_i  (m0_req),
    .req1_i  (m1_req),
    .ptr_i   (ptr_q),
    .valid_o (gnt_valid),
    .sel_o   (gnt_sel)
  );

  always_comb begin
    gnt_req_d = '{wr: m0_wr, video: m0_video, addr: m0_addr, wr_data: m0_wr_data};
    if (gnt_sel) begin
      gnt_req_d = '{wr: m1_wr, video: m1_video, addr: m1_addr, wr_data: m1_wr_data};
    end
  end

  // Video space is write-only, so a video read returns zero regardless of the bus.
  assign rd_capture_d = (req_q.video && !req_q.wr) ? '0 : fp_rd_data;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and block order does not matter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      owner_q    <= 1'b0;
      ptr_q      <= 1'b0;
      busy_q     <= 1'b0;
      mmio_cs_q  <= 1'b0;
      video_cs_q <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rd_q    <= '0;
      m1_rd_q    <= '0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            req_q      <= gnt_req_d;
            owner_q    <= gnt_sel;
            mmio_cs_q  <= ~gnt_req_d.video;
            video_cs_q <= gnt_req_d.video;
            wr_q       <= gnt_req_d.wr;
            rd_q       <= ~gnt_req_d.wr;
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mmio_cs_q  <= 1'b0;
          video_cs_q <= 1'b0;
          wr_q       <= 1'b0;
          rd_q       <= 1'b0;
          if (owner_q) begin
            m1_rd_q  <= rd_capture_d;
            m1_ack_q <= 1'b1;
          end else begin
            m0_rd_q  <= rd_capture_d;
            m0_ack_q <= 1'b1;
          end
          state_q <= ST_ACK;
        end
        ST_ACK: begin
          ptr_q   <= ~owner_q;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fp_mmio_cs  = mmio_cs_q;
  assign fp_video_cs = video_cs_q;
  assign fp_wr       = wr_q;
  assign fp_rd       = rd_q;
  assign fp_addr     = req_q.addr;
  assign fp_wr_data  = req_q.wr_data;
  assign m0_ack      = m0_ack_q;
  assign m1_ack      = m1_ack_q;
  assign m0_rd_data  = m0_rd_q;
  assign m1_rd_data  = m1_rd_q;
  assign busy        = busy_q;
  assign owner       = owner_q;

endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// Bench for fpro_bus_arbiter: a round-robin and a fixed-priority instance share
// one stimulus stream and are compared every cycle against a transfer-timeline model.
module tb_fpro_bus_arbiter;

  localparam int AW = 21;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          m0_req, m0_wr, m0_video, m1_req, m1_wr, m1_video;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wr_data, m1_wr_data, fp_rd_data;

  logic          o_m0_ack[2], o_m1_ack[2], o_mmio_cs[2], o_video_cs[2];
  logic          o_fp_wr[2], o_fp_rd[2], o_busy[2], o_owner[2];
  logic [DW-1:0] o_m0_rd[2], o_m1_rd[2], o_fp_wd[2];
  logic [AW-1:0] o_fp_addr[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    fpro_bus_arbiter #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .FIXED_PRIO (gi == 1)
    ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .m0_req      (m0_req),
      .m0_wr       (m0_wr),
      .m0_video    (m0_video),
      .m0_addr     (m0_addr),
      .m0_wr_data  (m0_wr_data),
      .m0_ack      (o_m0_ack[gi]),
      .m0_rd_data  (o_m0_rd[gi]),
      .m1_req      (m1_req),
      .m1_wr       (m1_wr),
      .m1_video    (m1_video),
      .m1_addr     (m1_addr),
      .m1_wr_data  (m1_wr_data),
      .m1_ack      (o_m1_ack[gi]),
      .m1_rd_data  (o_m1_rd[gi]),
      .fp_mmio_cs  (o_mmio_cs[gi]),
      .fp_video_cs (o_video_cs[gi]),
      .fp_wr       (o_fp_wr[gi]),
      .fp_rd       (o_fp_rd[gi]),
      .fp_addr     (o_fp_addr[gi]),
      .fp_wr_data  (o_fp_wd[gi]),
      .fp_rd_data  (fp_rd_data),
      .busy        (o_busy[gi]),
      .owner       (o_owner[gi])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a transfer granted at edge g strobes after edge g, acks after g+1,
  // and the next grant can happen no earlier than edge g+3.
  int            n = 0;
  bit            m_act[2], m_own[2], m_ptr[2], m_wr[2], m_vid[2];
  int            m_g[2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_wd[2], m_rd0[2], m_rd1[2];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 0; m_own[i] = 0; m_ptr[i] = 0; m_wr[i] = 0; m_vid[i] = 0;
        m_g[i] = 0; m_addr[i] = '0; m_wd[i] = '0; m_rd0[i] = '0; m_rd1[i] = '0;
      end
    end else begin
      n++;
      for (int i = 0; i < 2; i++) begin
        if (m_act[i] && n == m_g[i] + 1) begin
          if (m_own[i]) m_rd1[i] = (m_vid[i] && !m_wr[i]) ? '0 : fp_rd_data;
          else          m_rd0[i] = (m_vid[i] && !m_wr[i]) ? '0 : fp_rd_data;
        end
        if (m_act[i] && n == m_g[i] + 2) m_ptr[i] = !m_own[i];
        if (!m_act[i] || n >= m_g[i] + 3) begin
          m_act[i] = 0;
          if (m0_req || m1_req) begin
            bit win;
            if (i == 1)                win = !m0_req;
            else if (m0_req && m1_req) win = m_ptr[i];
            else                       win = m1_req;
            m_act[i]  = 1;
            m_g[i]    = n;
            m_own[i]  = win;
            m_wr[i]   = win ? m1_wr : m0_wr;
            m_vid[i]  = win ? m1_video : m0_video;
            m_addr[i] = win ? m1_addr : m0_addr;
            m_wd[i]   = win ? m1_wr_data : m0_wr_data;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit iss, ak;
      iss = m_act[i] && (n == m_g[i]);
      ak  = m_act[i] && (n == m_g[i] + 1);
      check($sformatf("mmio_cs[%0d]", i),  64'(o_mmio_cs[i]),  64'(iss && !m_vid[i]));
      check($sformatf("video_cs[%0d]", i), 64'(o_video_cs[i]), 64'(iss && m_vid[i]));
      check($sformatf("fp_wr[%0d]", i),    64'(o_fp_wr[i]),    64'(iss && m_wr[i]));
      check($sformatf("fp_rd[%0d]", i),    64'(o_fp_rd[i]),    64'(iss && !m_wr[i]));
      check($sformatf("fp_addr[%0d]", i),  64'(o_fp_addr[i]),  64'(m_addr[i]));
      check($sformatf("fp_wdata[%0d]", i), 64'(o_fp_wd[i]),    64'(m_wd[i]));
      check($sformatf("m0_ack[%0d]", i),   64'(o_m0_ack[i]),   64'(ak && !m_own[i]));
      check($sformatf("m1_ack[%0d]", i),   64'(o_m1_ack[i]),   64'(ak && m_own[i]));
      check($sformatf("m0_rd[%0d]", i),    64'(o_m0_rd[i]),    64'(m_rd0[i]));
      check($sformatf("m1_rd[%0d]", i),    64'(o_m1_rd[i]),    64'(m_rd1[i]));
      check($sformatf("busy[%0d]", i),     64'(o_busy[i]),     64'(iss || ak));
      check($sformatf("owner[%0d]", i),    64'(o_owner[i]),    64'(m_own[i]));
    end
  end

  task automatic idle(input int k);
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (k) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    m0_req = 0; m0_wr = 0; m0_video = 0; m0_addr = '0; m0_wr_data = '0;
    m1_req = 0; m1_wr = 0; m1_video = 0; m1_addr = '0; m1_wr_data = '0;
    fp_rd_data = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",  64'(o_busy[0]),    64'(0));
    check("rst_owner", 64'(o_owner[0]),   64'(0));
    check("rst_addr",  64'(o_fp_addr[0]), 64'(0));
    check("rst_m1rd",  64'(o_m1_rd[0]),   64'(0));
    #1 reset_n = 1'b1;
    idle(2);

    // m0 mmio write
    m0_req = 1; m0_wr = 1; m0_video = 0; m0_addr = 21'h00040; m0_wr_data = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_mmio_cs", 64'(o_mmio_cs[0]),  64'(1));
    check("t1_fp_wr",   64'(o_fp_wr[0]),    64'(1));
    check("t1_addr",    64'(o_fp_addr[0]),  64'(21'h00040));
    check("t1_wdata",   64'(o_fp_wd[0]),    64'(32'hDEADBEEF));
    #1 m0_req = 0;
    @(negedge clk);
    check("t1_m0_ack",  64'(o_m0_ack[0]),   64'(1));
    check("t1_m1_ack",  64'(o_m1_ack[0]),   64'(0));
    #1 idle(2);

    // m1 mmio read
    m1_req = 1; m1_wr = 0; m1_video = 0; m1_addr = 21'h00123; fp_rd_data = 32'h12345678;
    @(negedge clk);
    check("t2_fp_rd",   64'(o_fp_rd[0]),    64'(1));
    #1 m1_req = 0;
    @(negedge clk);
    check("t2_m1_ack",  64'(o_m1_ack[0]),   64'(1));
    check("t2_m1_rd",   64'(o_m1_rd[0]),    64'(32'h12345678));
    check("t2_m0_rd",   64'(o_m0_rd[0]),    64'(0));
    #1 idle(2);

    // m1 video read: write-only space returns zero
    m1_req = 1; m1_wr = 0; m1_video = 1; m1_addr = 21'h1FFFF; fp_rd_data = 32'hFFFFFFFF;
    @(negedge clk);
    check("t3_video_cs", 64'(o_video_cs[0]), 64'(1));
    check("t3_mmio_cs",  64'(o_mmio_cs[0]),  64'(0));
    check("t3_fp_rd",    64'(o_fp_rd[0]),    64'(1));
    #1 m1_req = 0;
    @(negedge clk);
    check("t3_m1_rd",    64'(o_m1_rd[0]),    64'(0));
    #1 idle(2);

    // both masters hold req: RR alternates, fixed always m0
    m0_req = 1; m0_wr = 1; m0_video = 0; m0_addr = 21'h00010; m0_wr_data = 32'hA0A0A0A0;
    m1_req = 1; m1_wr = 1; m1_video = 0; m1_addr = 21'h00020; m1_wr_data = 32'hB1B1B1B1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_owner",   64'(o_owner[0]), 64'(k % 2));
      check("rr_fp_wr",   64'(o_fp_wr[0]), 64'(1));
      check("fx_owner",   64'(o_owner[1]), 64'(0));
      @(negedge clk);
      check("rr_m0_ack",  64'(o_m0_ack[0]), 64'(k % 2 == 0));
      check("rr_m1_ack",  64'(o_m1_ack[0]), 64'(k % 2 == 1));
      check("fx_m1_ack",  64'(o_m1_ack[1]), 64'(0));
      @(negedge clk);
      check("rr_gap_busy", 64'(o_busy[0]),  64'(0));
    end
    #1 idle(2);

    // reset pulse during ISSUE
    m0_req = 1; m0_wr = 1; m0_video = 0; m0_addr = 21'h00055; m0_wr_data = 32'h01020304;
    @(negedge clk);
    check("rs_pre_wr", 64'(o_fp_wr[0]), 64'(1));
    #1 reset_n = 1'b0; m0_req = 0;
    #1;
    check("rs_fp_wr",   64'(o_fp_wr[0]),    64'(0));
    check("rs_fp_rd",   64'(o_fp_rd[0]),    64'(0));
    check("rs_mmio_cs", 64'(o_mmio_cs[0]),  64'(0));
    check("rs_vid_cs",  64'(o_video_cs[0]), 64'(0));
    check("rs_busy",    64'(o_busy[0]),     64'(0));
    @(negedge clk);
    check("rs_no_ack",  64'(o_m0_ack[0]),   64'(0));
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rs_no_ack2", 64'(o_m0_ack[0]),   64'(0));
    #1;
    m0_req = 1; m0_wr = 0; m1_req = 1; m1_wr = 0; m1_video = 0;
    @(negedge clk);
    check("rs_next_owner", 64'(o_owner[0]), 64'(0));
    #1 idle(3);

    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      reset_n    = ($urandom_range(0, 499) != 0);
      m0_req     = ($urandom_range(0, 99) < 55);
      m1_req     = ($urandom_range(0, 99) < 55);
      m0_wr      = $urandom_range(0, 1) != 0;
      m1_wr      = $urandom_range(0, 1) != 0;
      m0_video   = $urandom_range(0, 3) == 0;
      m1_video   = $urandom_range(0, 3) == 0;
      m0_addr    = AW'($urandom);
      m1_addr    = AW'($urandom);
      m0_wr_data = $urandom;
      m1_wr_data = $urandom;
      fp_rd_data = $urandom;
      @(negedge clk);
      #1;
    end
    reset_n = 1'b1;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
